seg_dynamic_param: RTL

SEG_DYNAMIC_PARAM -- requirements
Module: seg_dynamic_param

---
 rtl/seg_pkg.sv | 25 ++
 rtl/bin2bcd_seq.sv | 72 +++++++
 rtl/seg_dynamic_param.sv | 157 +++++++++++++++
 3 files changed

// File: rtl/seg_pkg.sv
// Shared segment codes and BCD digit type for the multiplexed 7-segment display.
// Segment bit order is {g,f,e,d,c,b,a}, active-high; output polarity is applied downstream.
package seg_pkg;

  typedef logic [3:0] bcd_t;

  localparam logic [9:0][6:0] SEG_DIGIT = {
    7'h6F, 7'h7F, 7'h07, 7'h7D, 7'h6D, 7'h66, 7'h4F, 7'h5B, 7'h06, 7'h3F
  };
  localparam logic [6:0] SEG_BLANK = 7'h00;
  localparam logic [6:0] SEG_MINUS = 7'h40;
  localparam logic [6:0] SEG_OVF   = 7'h49;

  function automatic logic [6:0] seg_of(input bcd_t d);
    return (d <= 4'd9) ? SEG_DIGIT[d] : SEG_BLANK;
  endfunction

  function automatic longint unsigned pow10(input int n);
    longint unsigned r;
    r = 64'd1;
    for (int i = 0; i < n; i++) r = r * 64'd10;
    return r;
  endfunction

endpackage

// File: rtl/bin2bcd_seq.sv
// Serial double-dabble converter: one bit per cycle, DATA_W cycles per conversion.
// done pulses with the final result on bcd in the same cycle busy drops.
module bin2bcd_seq
  import seg_pkg::*;
#(
  parameter int DATA_W = 20,
  parameter int DIGITS = 6
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  input  logic [DATA_W-1:0]       din,
  output logic                    busy,
  output logic                    done,
  output bcd_t [DIGITS-1:0]       bcd
);

  localparam int CNT_W = $clog2(DATA_W + 1);

  logic [DATA_W-1:0]     shift_q, shift_d;
  bcd_t [DIGITS-1:0]     bcd_q, bcd_d, adj;
  logic [4*DIGITS-1:0]   adj_flat;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic                  busy_q, busy_d;

  always_comb begin
    adj = bcd_q;
    for (int i = 0; i < DIGITS; i++) begin
      if (bcd_q[i] >= 4'd5) adj[i] = bcd_q[i] + 4'd3;
    end
    adj_flat = adj;

    shift_d = shift_q;
    bcd_d   = bcd_q;
    cnt_d   = cnt_q;
    busy_d  = busy_q;
    done    = 1'b0;
    if (busy_q) begin
      // carries out of the top digit are dropped; overflow is flagged separately
      bcd_d   = {adj_flat[4*DIGITS-2:0], shift_q[DATA_W-1]};
      shift_d = shift_q << 1;
      cnt_d   = cnt_q - CNT_W'(1);
      if (cnt_q == CNT_W'(1)) begin
        busy_d = 1'b0;
        done   = 1'b1;
      end
    end else if (start) begin
      shift_d = din;
      bcd_d   = '0;
      cnt_d   = CNT_W'(DATA_W);
      busy_d  = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      shift_q <= '0;
      bcd_q   <= '0;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
    end else begin
      shift_q <= shift_d;
      bcd_q   <= bcd_d;
      cnt_q   <= cnt_d;
      busy_q  <= busy_d;
    end
  end

  assign busy = busy_q;
  assign bcd  = bcd_d;

endmodule

// File: rtl/seg_dynamic_param.sv
// Multiplexed 7-segment driver: captures a binary value, converts to BCD serially,
// and scans digits with leading-zero blanking, sign, decimal points and PWM brightness.
module seg_dynamic_param
  import seg_pkg::*;
#(
  parameter int DIGITS      = 6,
  parameter int DATA_W      = 20,
  parameter int SCAN_DIV    = 50_000,
  parameter int SEG_ACT_LOW = 1
) (
  input  logic              sys_clk,
  input  logic              sys_rst,
  input  logic [DATA_W-1:0] data,
  input  logic [DIGITS-1:0] point,
  input  logic              sign,
  input  logic              load,
  input  logic              seg_en,
  input  logic [3:0]        bright,
  output logic              busy,
  output logic              ovf,
  output logic [DIGITS-1:0] sel,
  output logic [7:0]        seg
);

  localparam int IDX_W     = $clog2(DIGITS);
  localparam int HW        = IDX_W + 1;
  localparam int PHASE_LEN = SCAN_DIV / 16;
  localparam int SUB_W     = (PHASE_LEN > 1) ? $clog2(PHASE_LEN) : 1;
  localparam logic [DIGITS-1:0] SEL_OFF = (SEG_ACT_LOW != 0) ? {DIGITS{1'b1}} : {DIGITS{1'b0}};
  localparam logic [7:0]        SEG_OFF = (SEG_ACT_LOW != 0) ? 8'hFF : 8'h00;
  localparam longint unsigned   LIM_POS = pow10(DIGITS) - 64'd1;
  localparam longint unsigned   LIM_NEG = pow10(DIGITS - 1) - 64'd1;

  logic                  conv_busy, conv_done, start;
  bcd_t [DIGITS-1:0]     conv_bcd;

  logic [SUB_W-1:0]      sub_q, sub_d;
  logic [3:0]            phase_q, phase_d;
  logic [IDX_W-1:0]      digit_idx_q, digit_idx_d;
  logic [3:0]            bright_q, bright_d;
  logic                  slot_end, lit;

  logic [DIGITS-1:0]     pend_point_q, pend_point_d;
  logic                  pend_sign_q, pend_sign_d;
  logic                  pend_ovf_q, pend_ovf_d, ovf_new;
  bcd_t [DIGITS-1:0]     disp_digits_q, disp_digits_d;
  logic [DIGITS-1:0]     disp_point_q, disp_point_d;
  logic                  disp_sign_q, disp_sign_d;
  logic                  ovf_q, ovf_d;

  logic [HW-1:0]         h, cur_idx;
  logic [6:0]            seg7;
  logic                  dp;
  logic [DIGITS-1:0]     sel_ah, sel_d, sel_q;
  logic [7:0]            seg_ah, seg_d, seg_q;

  assign start = load && !conv_busy;

  bin2bcd_seq #(
    .DATA_W (DATA_W),
    .DIGITS (DIGITS)
  ) u_conv (
    .clk   (sys_clk),
    .rst   (sys_rst),
    .start (start),
    .din   (data),
    .busy  (conv_busy),
    .done  (conv_done),
    .bcd   (conv_bcd)
  );

  // capture on accept, publish everything together when the conversion finishes
  always_comb begin
    ovf_new = (64'(data) > LIM_POS) || (sign && (64'(data) > LIM_NEG));
    pend_point_d  = start ? point   : pend_point_q;
    pend_sign_d   = start ? sign    : pend_sign_q;
    pend_ovf_d    = start ? ovf_new : pend_ovf_q;
    disp_digits_d = conv_done ? conv_bcd     : disp_digits_q;
    disp_point_d  = conv_done ? pend_point_q : disp_point_q;
    disp_sign_d   = conv_done ? pend_sign_q  : disp_sign_q;
    ovf_d         = conv_done ? pend_ovf_q   : ovf_q;
  end

  // scan position is {phase_q, sub_q}; sub_q counts down within each phase
  always_comb begin
    slot_end    = (phase_q == 4'd15) && (sub_q == '0);
    sub_d       = (sub_q == '0) ? SUB_W'(PHASE_LEN - 1) : sub_q - SUB_W'(1);
    phase_d     = (sub_q == '0) ? phase_q + 4'd1 : phase_q;
    digit_idx_d = digit_idx_q;
    bright_d    = bright_q;
    if (slot_end) begin
      digit_idx_d = (digit_idx_q == IDX_W'(DIGITS - 1)) ? '0 : digit_idx_q + IDX_W'(1);
      bright_d    = bright;
    end
    lit = (phase_q != 4'd0) && ({1'b0, phase_q} <= ({1'b0, bright_q} + 5'd1));
  end

  always_comb begin
    h = '0;
    for (int i = 0; i < DIGITS; i++) begin
      if ((disp_digits_q[i] != 4'd0) || disp_point_q[i]) h = HW'(i);
    end
    cur_idx = {1'b0, digit_idx_q};
    dp      = disp_point_q[digit_idx_q] && !ovf_q;
    if (ovf_q)                                       seg7 = SEG_OVF;
    else if (cur_idx <= h)                           seg7 = seg_of(disp_digits_q[digit_idx_q]);
    else if (disp_sign_q && (cur_idx == h + HW'(1))) seg7 = SEG_MINUS;
    else                                             seg7 = SEG_BLANK;

    sel_ah = '0;
    seg_ah = '0;
    if (lit && seg_en) begin
      sel_ah[digit_idx_q] = 1'b1;
      seg_ah              = {dp, seg7};
    end
    sel_d = sel_ah ^ SEL_OFF;
    seg_d = seg_ah ^ SEG_OFF;
  end

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      sub_q         <= SUB_W'(PHASE_LEN - 1);
      phase_q       <= '0;
      digit_idx_q   <= '0;
      bright_q      <= '0;
      pend_point_q  <= '0;
      pend_sign_q   <= 1'b0;
      pend_ovf_q    <= 1'b0;
      disp_digits_q <= '0;
      disp_point_q  <= '0;
      disp_sign_q   <= 1'b0;
      ovf_q         <= 1'b0;
      sel_q         <= SEL_OFF;
      seg_q         <= SEG_OFF;
    end else begin
      sub_q         <= sub_d;
      phase_q       <= phase_d;
      digit_idx_q   <= digit_idx_d;
      bright_q      <= bright_d;
      pend_point_q  <= pend_point_d;
      pend_sign_q   <= pend_sign_d;
      pend_ovf_q    <= pend_ovf_d;
      disp_digits_q <= disp_digits_d;
      disp_point_q  <= disp_point_d;
      disp_sign_q   <= disp_sign_d;
      ovf_q         <= ovf_d;
      sel_q         <= sel_d;
      seg_q         <= seg_d;
    end
  end

  assign busy = conv_busy;
  assign ovf  = ovf_q;
  assign sel  = sel_q;
  assign seg  = seg_q;

endmodule
